// File: rtl/reg_file_pkg.sv
// Shared register-map constants, CTRL/STATUS bit positions and the STATUS payload for reg_file.
package reg_file_pkg;

  localparam int unsigned RF_ADDR_WIDTH = 7;
  localparam int unsigned RF_DATA_WIDTH = 8;

  localparam logic [RF_ADDR_WIDTH-1:0] RF_ADDR_CTRL     = 7'h00;
  localparam logic [RF_ADDR_WIDTH-1:0] RF_ADDR_FTW0     = 7'h01;
  localparam logic [RF_ADDR_WIDTH-1:0] RF_ADDR_FTW1     = 7'h02;
  localparam logic [RF_ADDR_WIDTH-1:0] RF_ADDR_FTW2     = 7'h03;
  localparam logic [RF_ADDR_WIDTH-1:0] RF_ADDR_FTW3     = 7'h04;
  localparam logic [RF_ADDR_WIDTH-1:0] RF_ADDR_AMPL     = 7'h05;
  localparam logic [RF_ADDR_WIDTH-1:0] RF_ADDR_PTR_L    = 7'h06;
  localparam logic [RF_ADDR_WIDTH-1:0] RF_ADDR_PTR_H    = 7'h07;
  localparam logic [RF_ADDR_WIDTH-1:0] RF_ADDR_RAM_DATA = 7'h08;
  localparam logic [RF_ADDR_WIDTH-1:0] RF_ADDR_STATUS   = 7'h09;
  localparam logic [RF_ADDR_WIDTH-1:0] RF_ADDR_ID       = 7'h0A;

  localparam int unsigned CTRL_OUT_EN_BIT   = 0;
  localparam int unsigned CTRL_COMMIT_BIT   = 1;
  localparam int unsigned CTRL_WAVE_LSB     = 2;
  localparam int unsigned CTRL_SOFT_RST_BIT = 7;

  localparam logic [7:0] RF_ID_VALUE = 8'hA5;
  localparam logic       RST_ACT     = 1'b1;

  // Bit order matches the STATUS register: b0 commit_done, b1 ram_wrap, b2 bad_addr.
  typedef struct packed {
    logic bad_addr;
    logic ram_wrap;
    logic commit_done;
  } status_t;

endpackage

// File: rtl/reg_file_ram_port.sv
// Sample-RAM port: auto-incrementing pointer with wrap, registered write strobe, address tracking.
// RF_RAM_READBACK_EN: ram_addr_o follows the pointer continuously so reads see RAM at the pointer.
module reg_file_ram_port
  import reg_file_pkg::*;
#(
  parameter int unsigned RAM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_rst_i,
  input  logic              ptr_lo_we_i,
  input  logic              ptr_hi_we_i,
  input  logic              data_we_i,
  input  logic              data_re_i,
  input  logic [7:0]        wdata_i,
  output logic [RAM_AW-1:0] ptr_o,
  output logic              wrap_c,
  output logic              ram_we_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [7:0]        ram_wdata_o
);

  logic [RAM_AW-1:0] ptr_q, ptr_d;
  logic              ram_we_q, ram_we_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;
  logic              step_c;

  assign step_c = data_we_i | data_re_i;

  always_comb begin
    ptr_d       = ptr_q;
    ram_we_d    = data_we_i;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    wrap_c      = 1'b0;

    if (ptr_lo_we_i) ptr_d[7:0] = wdata_i;
    if (ptr_hi_we_i) ptr_d[RAM_AW-1:8] = wdata_i[RAM_AW-9:0];

    if (step_c) begin
      ptr_d  = ptr_q + RAM_AW'(1);
      wrap_c = &ptr_q;
    end

    // Write strobe carries the pre-increment pointer; otherwise the address may follow the pointer.
    if (data_we_i) begin
      ram_addr_d  = ptr_q;
      ram_wdata_d = wdata_i;
    end
`ifdef RF_RAM_READBACK_EN
    else begin
      ram_addr_d = ptr_d;
    end
`endif

    if (soft_rst_i) begin
      ptr_d       = '0;
      ram_we_d    = 1'b0;
      ram_addr_d  = '0;
      ram_wdata_d = '0;
      wrap_c      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ACT) begin
      ptr_q       <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign ptr_o       = ptr_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;

endmodule

// File: rtl/reg_file.sv
// Control/status register file behind the SPI slave: shadow/active FTW+AMPL, sample RAM port, sticky STATUS.
// RF_RAM_READBACK_EN: RAM_DATA reads return ram_rdata_i and advance the pointer.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned RF_ADDR_W = RF_ADDR_WIDTH,
  parameter int unsigned RF_DATA_W = RF_DATA_WIDTH,
  parameter int unsigned RAM_AW    = 10
) (
  input  logic                 sys_clk_i,
  input  logic                 sys_rst_i,
  input  logic                 rf_re_i,
  input  logic                 rf_we_i,
  input  logic [RF_ADDR_W-1:0] rf_addr_i,
  input  logic [RF_DATA_W-1:0] rf_data_i,
  output logic [RF_DATA_W-1:0] rf_data_o,
  output logic                 out_en_o,
  output logic [1:0]           wave_sel_o,
  output logic [31:0]          ftw_o,
  output logic [7:0]           ampl_o,
  output logic                 commit_o,
  output logic                 soft_rst_o,
  output logic                 ram_we_o,
  output logic [RAM_AW-1:0]    ram_addr_o,
  output logic [7:0]           ram_wdata_o,
  input  logic [7:0]           ram_rdata_i
);

  logic          out_en_q, out_en_d;
  logic [1:0]    wave_sel_q, wave_sel_d;
  logic [31:0]   ftw_sh_q, ftw_sh_d;
  logic [7:0]    ampl_sh_q, ampl_sh_d;
  logic [31:0]   ftw_q, ftw_d;
  logic [7:0]    ampl_q, ampl_d;
  logic          commit_q, commit_d;
  logic          soft_rst_q, soft_rst_d;
  status_t       status_q, status_d;

  logic [7:0]        wdata_c;
  logic              rd_c;
  logic              wr_ctrl_c, soft_c, commit_c, bad_c, rd_status_c;
  logic              ram_data_re_c;
  logic              wrap_c;
  logic [RAM_AW-1:0] ptr_c;

  assign wdata_c = rf_data_i[7:0];
  // A simultaneous write takes priority and suppresses read side-effects.
  assign rd_c        = rf_re_i & ~rf_we_i;
  assign wr_ctrl_c   = rf_we_i && (rf_addr_i == RF_ADDR_W'(RF_ADDR_CTRL));
  assign soft_c      = wr_ctrl_c & wdata_c[CTRL_SOFT_RST_BIT];
  assign commit_c    = wr_ctrl_c & wdata_c[CTRL_COMMIT_BIT] & ~soft_c;
  assign bad_c       = rf_we_i && (rf_addr_i > RF_ADDR_W'(RF_ADDR_ID));
  assign rd_status_c = rd_c && (rf_addr_i == RF_ADDR_W'(RF_ADDR_STATUS));

`ifdef RF_RAM_READBACK_EN
  assign ram_data_re_c = rd_c && (rf_addr_i == RF_ADDR_W'(RF_ADDR_RAM_DATA));
`else
  logic unused_rdata;
  assign ram_data_re_c = 1'b0;
  assign unused_rdata  = ^ram_rdata_i;
`endif

  reg_file_ram_port #(
    .RAM_AW (RAM_AW)
  ) u_ram_port (
    .clk         (sys_clk_i),
    .rst         (sys_rst_i),
    .soft_rst_i  (soft_c),
    .ptr_lo_we_i (rf_we_i && (rf_addr_i == RF_ADDR_W'(RF_ADDR_PTR_L))),
    .ptr_hi_we_i (rf_we_i && (rf_addr_i == RF_ADDR_W'(RF_ADDR_PTR_H))),
    .data_we_i   (rf_we_i && (rf_addr_i == RF_ADDR_W'(RF_ADDR_RAM_DATA))),
    .data_re_i   (ram_data_re_c),
    .wdata_i     (wdata_c),
    .ptr_o       (ptr_c),
    .wrap_c      (wrap_c),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o)
  );

  always_comb begin
    out_en_d   = out_en_q;
    wave_sel_d = wave_sel_q;
    ftw_sh_d   = ftw_sh_q;
    ampl_sh_d  = ampl_sh_q;
    ftw_d      = ftw_q;
    ampl_d     = ampl_q;
    commit_d   = 1'b0;
    soft_rst_d = 1'b0;

    if (wr_ctrl_c) begin
      out_en_d   = wdata_c[CTRL_OUT_EN_BIT];
      wave_sel_d = wdata_c[CTRL_WAVE_LSB +: 2];
    end

    if (rf_we_i) begin
      case (rf_addr_i)
        RF_ADDR_W'(RF_ADDR_FTW0): ftw_sh_d[7:0]   = wdata_c;
        RF_ADDR_W'(RF_ADDR_FTW1): ftw_sh_d[15:8]  = wdata_c;
        RF_ADDR_W'(RF_ADDR_FTW2): ftw_sh_d[23:16] = wdata_c;
        RF_ADDR_W'(RF_ADDR_FTW3): ftw_sh_d[31:24] = wdata_c;
        RF_ADDR_W'(RF_ADDR_AMPL): ampl_sh_d       = wdata_c;
        default: ;
      endcase
    end

    if (commit_c) begin
      ftw_d    = ftw_sh_q;
      ampl_d   = ampl_sh_q;
      commit_d = 1'b1;
    end

    // Clear-on-read first so a same-cycle set survives.
    status_d = rd_status_c ? '0 : status_q;
    status_d.commit_done = status_d.commit_done | commit_c;
    status_d.ram_wrap    = status_d.ram_wrap | wrap_c;
    status_d.bad_addr    = status_d.bad_addr | bad_c;

    if (soft_c) begin
      out_en_d   = 1'b0;
      wave_sel_d = '0;
      ftw_sh_d   = '0;
      ampl_sh_d  = '0;
      ftw_d      = '0;
      ampl_d     = '0;
      commit_d   = 1'b0;
      status_d   = '0;
      soft_rst_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i == RST_ACT) begin
      out_en_q   <= 1'b0;
      wave_sel_q <= '0;
      ftw_sh_q   <= '0;
      ampl_sh_q  <= '0;
      ftw_q      <= '0;
      ampl_q     <= '0;
      commit_q   <= 1'b0;
      soft_rst_q <= 1'b0;
      status_q   <= '0;
    end else begin
      out_en_q   <= out_en_d;
      wave_sel_q <= wave_sel_d;
      ftw_sh_q   <= ftw_sh_d;
      ampl_sh_q  <= ampl_sh_d;
      ftw_q      <= ftw_d;
      ampl_q     <= ampl_d;
      commit_q   <= commit_d;
      soft_rst_q <= soft_rst_d;
      status_q   <= status_d;
    end
  end

  // Zero-latency readback mux; write-only CTRL bits read as 0.
  always_comb begin
    rf_data_o = '0;
    case (rf_addr_i)
      RF_ADDR_W'(RF_ADDR_CTRL):  rf_data_o = RF_DATA_W'({4'b0, wave_sel_q, 1'b0, out_en_q});
      RF_ADDR_W'(RF_ADDR_FTW0):  rf_data_o = RF_DATA_W'(ftw_sh_q[7:0]);
      RF_ADDR_W'(RF_ADDR_FTW1):  rf_data_o = RF_DATA_W'(ftw_sh_q[15:8]);
      RF_ADDR_W'(RF_ADDR_FTW2):  rf_data_o = RF_DATA_W'(ftw_sh_q[23:16]);
      RF_ADDR_W'(RF_ADDR_FTW3):  rf_data_o = RF_DATA_W'(ftw_sh_q[31:24]);
      RF_ADDR_W'(RF_ADDR_AMPL):  rf_data_o = RF_DATA_W'(ampl_sh_q);
      RF_ADDR_W'(RF_ADDR_PTR_L): rf_data_o = RF_DATA_W'(ptr_c[7:0]);
      RF_ADDR_W'(RF_ADDR_PTR_H): rf_data_o = RF_DATA_W'(ptr_c[RAM_AW-1:8]);
`ifdef RF_RAM_READBACK_EN
      RF_ADDR_W'(RF_ADDR_RAM_DATA): rf_data_o = RF_DATA_W'(ram_rdata_i);
`endif
      RF_ADDR_W'(RF_ADDR_STATUS): rf_data_o = RF_DATA_W'(status_q);
      RF_ADDR_W'(RF_ADDR_ID):     rf_data_o = RF_DATA_W'(RF_ID_VALUE);
      default: ;
    endcase
  end

  assign out_en_o   = out_en_q;
  assign wave_sel_o = wave_sel_q;
  assign ftw_o      = ftw_q;
  assign ampl_o     = ampl_q;
  assign commit_o   = commit_q;
  assign soft_rst_o = soft_rst_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file with a behavioural sample RAM; follows RF_RAM_READBACK_EN like the DUT.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic        rf_re;
  logic        rf_we;
  logic [6:0]  rf_addr;
  logic [7:0]  rf_wdata;
  logic [7:0]  rf_rdata;
  logic        out_en;
  logic [1:0]  wave_sel;
  logic [31:0] ftw;
  logic [7:0]  ampl;
  logic        commit;
  logic        soft_rst;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  logic [7:0]  mem [1024];
  int          n_checks;
  int          n_fail;
  logic [7:0]  d;

  reg_file #(.RF_ADDR_W(7), .RF_DATA_W(8), .RAM_AW(10)) dut (
    .sys_clk_i   (clk),
    .sys_rst_i   (rst),
    .rf_re_i     (rf_re),
    .rf_we_i     (rf_we),
    .rf_addr_i   (rf_addr),
    .rf_data_i   (rf_wdata),
    .rf_data_o   (rf_rdata),
    .out_en_o    (out_en),
    .wave_sel_o  (wave_sel),
    .ftw_o       (ftw),
    .ampl_o      (ampl),
    .commit_o    (commit),
    .soft_rst_o  (soft_rst),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read sample RAM
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    ram_rdata = 8'h00;
  end
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rf_write(input logic [6:0] a, input logic [7:0] v);
    @(negedge clk);
    rf_we = 1'b1; rf_addr = a; rf_wdata = v;
    @(negedge clk);
    rf_we = 1'b0;
  endtask

  task automatic rf_read(input logic [6:0] a, output logic [7:0] v);
    @(negedge clk);
    rf_re = 1'b1; rf_addr = a;
    #1 v = rf_rdata;
    @(negedge clk);
    rf_re = 1'b0;
  endtask

  task automatic rf_rw(input logic [6:0] a, input logic [7:0] v);
    @(negedge clk);
    rf_re = 1'b1; rf_we = 1'b1; rf_addr = a; rf_wdata = v;
    @(negedge clk);
    rf_re = 1'b0; rf_we = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; rf_re = 1'b0; rf_we = 1'b0; rf_addr = '0; rf_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_eq("rst_out_en", 32'(out_en), 32'h0);
    check_eq("rst_wave_sel", 32'(wave_sel), 32'h0);
    check_eq("rst_ftw", ftw, 32'h0);
    check_eq("rst_ampl", 32'(ampl), 32'h0);
    check_eq("rst_commit", 32'(commit), 32'h0);
    check_eq("rst_soft_rst", 32'(soft_rst), 32'h0);
    check_eq("rst_ram_we", 32'(ram_we), 32'h0);
    check_eq("rst_ram_addr", 32'(ram_addr), 32'h0);
    check_eq("rst_ram_wdata", 32'(ram_wdata), 32'h0);
    rf_read(7'h0A, d); check_eq("rst_id", 32'(d), 32'hA5);
    for (int a = 0; a < 10; a++) begin
      rf_read(7'(a), d);
      check_eq($sformatf("rst_reg%0d", a), 32'(d), 32'h0);
    end

    // Shadow FTW/AMPL then commit
    rf_write(7'h01, 8'h78); rf_write(7'h02, 8'h56);
    rf_write(7'h03, 8'h34); rf_write(7'h04, 8'h12);
    rf_write(7'h05, 8'h40);
    check_eq("shadow_ftw_hidden", ftw, 32'h0);
    check_eq("shadow_ampl_hidden", 32'(ampl), 32'h0);
    rf_read(7'h01, d); check_eq("ftw0_readback", 32'(d), 32'h78);
    rf_write(7'h00, 8'h03);
    check_eq("commit_ftw", ftw, 32'h12345678);
    check_eq("commit_ampl", 32'(ampl), 32'h40);
    check_eq("commit_pulse", 32'(commit), 32'h1);
    check_eq("commit_out_en", 32'(out_en), 32'h1);
    @(negedge clk);
    check_eq("commit_pulse_end", 32'(commit), 32'h0);
    rf_read(7'h00, d); check_eq("ctrl_read", 32'(d), 32'h01);
    rf_read(7'h09, d); check_eq("status_commit", 32'(d), 32'h01);
    rf_read(7'h09, d); check_eq("status_cleared", 32'(d), 32'h00);
    rf_write(7'h00, 8'h0D);
    check_eq("wave_sel", 32'(wave_sel), 32'h3);
    check_eq("no_commit", 32'(commit), 32'h0);
    rf_read(7'h00, d); check_eq("ctrl_read2", 32'(d), 32'h0D);

    // RAM writes across the pointer wrap
    rf_write(7'h06, 8'hFE); rf_write(7'h07, 8'h03);
    rf_read(7'h07, d); check_eq("ptr_h_read", 32'(d), 32'h03);
    rf_write(7'h08, 8'hAA);
    check_eq("ram_we0", 32'(ram_we), 32'h1);
    check_eq("ram_addr0", 32'(ram_addr), 32'h3FE);
    check_eq("ram_wdata0", 32'(ram_wdata), 32'hAA);
    rf_write(7'h08, 8'hBB);
    check_eq("ram_addr1", 32'(ram_addr), 32'h3FF);
    check_eq("ram_wdata1", 32'(ram_wdata), 32'hBB);
    rf_write(7'h08, 8'hCC);
    check_eq("ram_we2", 32'(ram_we), 32'h1);
    check_eq("ram_addr2", 32'(ram_addr), 32'h000);
    check_eq("ram_wdata2", 32'(ram_wdata), 32'hCC);
    @(negedge clk);
    check_eq("ram_we_end", 32'(ram_we), 32'h0);
    rf_read(7'h09, d); check_eq("status_wrap", 32'(d), 32'h02);
    rf_read(7'h06, d); check_eq("ptr_l_after_wrap", 32'(d), 32'h01);
    rf_read(7'h07, d); check_eq("ptr_h_after_wrap", 32'(d), 32'h00);

    // Unmapped write, read-only writes, simultaneous read+write on STATUS
    rf_write(7'h20, 8'h55);
    check_eq("bad_ftw_kept", ftw, 32'h12345678);
    check_eq("bad_out_en_kept", 32'(out_en), 32'h1);
    rf_read(7'h20, d); check_eq("bad_read", 32'(d), 32'h00);
    rf_write(7'h20, 8'h55);
    rf_rw(7'h09, 8'hFF);
    rf_read(7'h09, d); check_eq("status_bad_kept", 32'(d), 32'h04);
    rf_write(7'h0A, 8'h00);
    rf_read(7'h0A, d); check_eq("id_write_ignored", 32'(d), 32'hA5);
    rf_read(7'h09, d); check_eq("ro_no_bad", 32'(d), 32'h00);

    // RAM readback
    rf_write(7'h07, 8'h00); rf_write(7'h06, 8'h10);
    rf_write(7'h08, 8'h5A); rf_write(7'h08, 8'h5B);
    rf_write(7'h06, 8'h10);
`ifdef RF_RAM_READBACK_EN
    rf_read(7'h08, d); check_eq("rb_data0", 32'(d), 32'h5A);
    rf_read(7'h08, d); check_eq("rb_data1", 32'(d), 32'h5B);
    rf_read(7'h06, d); check_eq("rb_ptr", 32'(d), 32'h12);
`else
    rf_read(7'h08, d); check_eq("rb_data0", 32'(d), 32'h00);
    rf_read(7'h08, d); check_eq("rb_data1", 32'(d), 32'h00);
    rf_read(7'h06, d); check_eq("rb_ptr", 32'(d), 32'h10);
`endif

    // Soft reset
    rf_write(7'h20, 8'h01);
    rf_write(7'h00, 8'h80);
    check_eq("soft_pulse", 32'(soft_rst), 32'h1);
    check_eq("soft_ftw", ftw, 32'h0);
    check_eq("soft_ampl", 32'(ampl), 32'h0);
    check_eq("soft_out_en", 32'(out_en), 32'h0);
    check_eq("soft_wave_sel", 32'(wave_sel), 32'h0);
    @(negedge clk);
    check_eq("soft_pulse_end", 32'(soft_rst), 32'h0);
    rf_read(7'h01, d); check_eq("soft_ftw0", 32'(d), 32'h00);
    rf_read(7'h05, d); check_eq("soft_ampl_sh", 32'(d), 32'h00);
    rf_read(7'h06, d); check_eq("soft_ptr", 32'(d), 32'h00);
    rf_read(7'h09, d); check_eq("soft_status", 32'(d), 32'h00);
    rf_read(7'h10 - 7'h06, d); check_eq("soft_ram_data_mem", 32'(mem[10'h011]), 32'h5B);

    // Reset overrides a commit strobe on the same edge
    rf_write(7'h01, 8'h11);
    @(negedge clk);
    rst = 1'b1; rf_we = 1'b1; rf_addr = 7'h00; rf_wdata = 8'h03;
    @(negedge clk);
    rf_we = 1'b0; rst = 1'b0;
    check_eq("rst_over_commit", 32'(commit), 32'h0);
    check_eq("rst_over_ftw", ftw, 32'h0);
    check_eq("rst_over_out_en", 32'(out_en), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
